pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_pkg.sv | 24 ++
 rtl/pwm_prescaler.sv | 31 +++
 rtl/pwm_bank.sv | 128 ++++++++++++
 tb/tb_pwm_bank.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM bank: mode/direction encodings, default
// parameter values and the channel-index width helper.
package pwm_bank_pkg;

  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_PRESCALE_W = 16;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM bank: one tick every prescale+1 enabled clocks.
module pwm_prescaler
  import pwm_bank_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_tick;

  // >= rather than == so a prescale lowered mid-count still ticks promptly.
  assign w_tick = ena && (r_cnt >= prescale);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= w_tick ? '0 : (r_cnt + P_ONE);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter and
// double-buffered duty registers that load on each period boundary.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [PRESCALE_W-1:0]       prescale,
  input  logic                        mode,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic                        duty_we,
  input  logic [idx_w(NUM_CH)-1:0]    duty_ch,
  input  logic [CNT_W-1:0]            duty_val,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        period_start
);

  localparam int                CH_W    = idx_w(NUM_CH);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic              w_tick;
  logic              w_boundary;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  cnt_dir_e          r_dir;
  cnt_dir_e          w_dir_nxt;
  pwm_mode_e         r_mode;
  logic              r_period_start;
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] r_pwm;

  pwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .prescale (prescale),
    .tick     (w_tick)
  );

  // Counter/direction next state. The boundary is the tick that lands the
  // counter on 0: the edge-mode wrap or the last step of the center descent.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_boundary = 1'b0;
    if (w_tick) begin
      if (r_mode == MODE_EDGE) begin
        w_cnt_nxt  = r_cnt + CNT_ONE;
        w_boundary = (r_cnt == CNT_MAX);
      end else if (r_dir == DIR_UP) begin
        if (r_cnt == CNT_MAX) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          w_dir_nxt = DIR_DOWN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end else begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_dir_nxt  = DIR_UP;
          w_boundary = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_dir          <= DIR_UP;
      r_mode         <= MODE_EDGE;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_dir          <= w_dir_nxt;
      r_period_start <= w_boundary;
      if (w_boundary) begin
        r_mode <= pwm_mode_e'(mode);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic             w_wr;

    // Indices with no matching channel decode to no write at all.
    assign w_wr = duty_we && (duty_ch == CH_W'(gi));
    assign w_raw[gi] = (r_active == CNT_MAX) || (r_cnt < r_active);

    // On a boundary the active value takes the shadow as it was before any
    // write landing in the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_boundary) begin
          r_active <= r_shadow;
        end
        if (w_wr) begin
          r_shadow <= duty_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_raw & ch_en & {NUM_CH{ena}};
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: a period-position model checked every clock,
// plus per-period duty/length measurements against hand-computed numbers.
module tb_pwm_bank;
  import pwm_bank_pkg::*;

  // Six channels keep a 3-bit index, so indices 6 and 7 exist but select nothing.
  localparam int NUM_CH     = 6;
  localparam int CNT_W      = 8;
  localparam int PRESCALE_W = 16;
  localparam int CH_W       = 3;
  localparam int MAXV       = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ena = 1'b0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic                  mode = 1'b0;
  logic [NUM_CH-1:0]     ch_en = '0;
  logic                  duty_we = 1'b0;
  logic [CH_W-1:0]       duty_ch = '0;
  logic [CNT_W-1:0]      duty_val = '0;
  logic [NUM_CH-1:0]     pwm_out;
  logic                  period_start;

  int checks = 0;
  int errors = 0;

  pwm_bank #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .prescale     (prescale),
    .mode         (mode),
    .ch_en        (ch_en),
    .duty_we      (duty_we),
    .duty_ch      (duty_ch),
    .duty_val     (duty_val),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the position within the period (ticks since the boundary) and
  // derives the counter value from it arithmetically.
  int                m_pre;
  int                m_pos;
  int                m_mode;
  int                m_duty[NUM_CH];
  int                m_shadow[NUM_CH];
  logic [NUM_CH-1:0] m_pwm;
  logic              m_ps;

  function automatic int cnt_at(input int pos, input int md);
    if (md == 0 || pos <= MAXV) return pos;
    return 2 * MAXV - pos;
  endfunction

  function automatic int period_len(input int md);
    return (md == 0) ? MAXV + 1 : 2 * MAXV;
  endfunction

  task automatic model_clear();
    m_pre = 0; m_pos = 0; m_mode = 0; m_pwm = '0; m_ps = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_duty[i] = 0;
      m_shadow[i] = 0;
    end
  endtask

  task automatic model_step();
    int                c;
    int                idx;
    bit                tk;
    bit                bnd;
    logic [NUM_CH-1:0] nxt;
    c = cnt_at(m_pos, m_mode);
    for (int i = 0; i < NUM_CH; i++) nxt[i] = (m_duty[i] == MAXV) || (c < m_duty[i]);
    nxt = nxt & ch_en & {NUM_CH{ena}};
    tk  = ena && (m_pre >= int'(prescale));
    bnd = tk && (m_pos + 1 == period_len(m_mode));
    if (ena) m_pre = tk ? 0 : m_pre + 1;
    if (tk) m_pos = bnd ? 0 : m_pos + 1;
    if (bnd) begin
      for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_shadow[i];
      m_mode = int'(mode);
    end
    idx = int'(duty_ch);
    if (duty_we && idx < NUM_CH) m_shadow[idx] = int'(duty_val);
    m_pwm = nxt;
    m_ps  = bnd;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step();
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("model_period_start", 32'(period_start), 32'(m_ps));
    end
  end

  // ---------------- driver tasks ----------------
  int ms_len;
  int ms_high[NUM_CH];

  task automatic write_duty(input int ch, input int val);
    duty_we  = 1'b1;
    duty_ch  = CH_W'(ch);
    duty_val = CNT_W'(val);
    @(posedge clk); #1;
    duty_we  = 1'b0;
  endtask

  // Entered on a sample showing period_start; samples through the next
  // period_start, so each channel count covers exactly one period's counter
  // values. Optional one-shot write at wr_at and ena-low window at off_at.
  task automatic measure(input int wr_at, input int wr_ch, input int wr_val,
                         input int off_at, input int off_len);
    bit seen;
    seen   = 1'b0;
    ms_len = 0;
    for (int i = 0; i < NUM_CH; i++) ms_high[i] = 0;
    for (int off = 0; off < 2000 && !seen; off++) begin
      if (off == wr_at) begin
        duty_we  = 1'b1;
        duty_ch  = CH_W'(wr_ch);
        duty_val = CNT_W'(wr_val);
      end
      if (off == off_at) ena = 1'b0;
      if (off == off_at + off_len) ena = 1'b1;
      @(posedge clk); #1;
      duty_we = 1'b0;
      ms_len++;
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) ms_high[i]++;
      if (off == off_at) check("pause_outputs_low", 32'(pwm_out), 32'd0);
      if (period_start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL measure_timeout: got no period_start expected one within 2000 clocks");
    end
  endtask

  task automatic wait_first_ps(input int start, output int clocks, output int high0);
    bit seen;
    seen   = 1'b0;
    clocks = start;
    high0  = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge clk); #1;
      clocks++;
      if (pwm_out[0]) high0++;
      if (period_start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL first_period_timeout: got no period_start expected one within 2000 clocks");
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int clocks;
    int high0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm_out", 32'(pwm_out), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);
    cmp_on   = 1'b1;
    prescale = '0;
    mode     = 1'b0;
    ch_en    = 6'b001111;
    ena      = 1'b1;
    rst_n    = 1'b1;

    // First period after reset: all duties 0, first pulse after 256 clocks.
    write_duty(0, 64);
    write_duty(1, 0);
    write_duty(2, 255);
    write_duty(3, 100);
    wait_first_ps(4, clocks, high0);
    check("first_period_len", 32'(clocks), 32'd256);
    check("first_period_ch0_high", 32'(high0), 32'd0);

    measure(-1, 0, 0, -1, 0);
    check("edge_len", 32'(ms_len), 32'd256);
    check("edge_ch0_64", 32'(ms_high[0]), 32'd64);
    check("edge_ch1_zero", 32'(ms_high[1]), 32'd0);
    check("edge_ch2_full", 32'(ms_high[2]), 32'd256);
    check("edge_ch3_100", 32'(ms_high[3]), 32'd100);
    check("edge_ch4_unset", 32'(ms_high[4]), 32'd0);

    measure(-1, 0, 0, -1, 0);
    check("edge_ch2_full_wrap", 32'(ms_high[2]), 32'd256);

    ch_en = 6'b001011;
    measure(-1, 0, 0, -1, 0);
    check("ch2_disabled", 32'(ms_high[2]), 32'd0);
    check("ch0_still_64", 32'(ms_high[0]), 32'd64);

    // Mid-period write: current period keeps 64, next period shows 200.
    measure(100, 0, 200, -1, 0);
    check("dbuf_cur_64", 32'(ms_high[0]), 32'd64);
    measure(-1, 0, 0, -1, 0);
    check("dbuf_next_200", 32'(ms_high[0]), 32'd200);

    // Write in the boundary clock (counter 255): effective one period later.
    measure(255, 0, 32, -1, 0);
    check("bwr_cur_200", 32'(ms_high[0]), 32'd200);
    measure(-1, 0, 0, -1, 0);
    check("bwr_next_200", 32'(ms_high[0]), 32'd200);
    measure(-1, 0, 0, -1, 0);
    check("bwr_later_32", 32'(ms_high[0]), 32'd32);

    // Unused indices must not touch any channel.
    measure(10, 6, 17, -1, 0);
    measure(10, 7, 99, -1, 0);
    measure(-1, 0, 0, -1, 0);
    check("oor_ch0", 32'(ms_high[0]), 32'd32);
    check("oor_ch1", 32'(ms_high[1]), 32'd0);
    check("oor_ch3", 32'(ms_high[3]), 32'd100);
    check("oor_ch4", 32'(ms_high[4]), 32'd0);
    check("oor_ch5", 32'(ms_high[5]), 32'd0);

    // ena low for 30 clocks while the counter sits at 50.
    measure(-1, 0, 0, 50, 30);
    check("pause_len", 32'(ms_len), 32'd286);
    check("pause_ch3_100", 32'(ms_high[3]), 32'd100);
    check("pause_ch0_32", 32'(ms_high[0]), 32'd32);

    // Mode raised just after a boundary: this period stays edge-aligned.
    mode = 1'b1;
    measure(-1, 0, 0, -1, 0);
    check("mode_mid_len", 32'(ms_len), 32'd256);

    // Center, prescale 1: 510 ticks of 2 clocks. Counter values below 100
    // are 0..99 up and 99..1 down = 199 ticks; below 32 it is 63 ticks.
    prescale = 16'd1;
    measure(-1, 0, 0, -1, 0);
    check("center_len", 32'(ms_len), 32'd1020);
    check("center_ch3", 32'(ms_high[3]), 32'd398);
    check("center_ch0", 32'(ms_high[0]), 32'd126);
    measure(-1, 0, 0, -1, 0);
    check("center_len2", 32'(ms_len), 32'd1020);
    check("center_ch3_2", 32'(ms_high[3]), 32'd398);

    // Pending shadow then asynchronous reset mid-period.
    write_duty(0, 150);
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_ch3_high", 32'(pwm_out[3]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm_out), 32'd0);
    check("async_reset_ps", 32'(period_start), 32'd0);
    mode     = 1'b0;
    prescale = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_first_ps(0, clocks, high0);
    check("rst_first_len", 32'(clocks), 32'd256);
    check("rst_first_ch0", 32'(high0), 32'd0);
    measure(-1, 0, 0, -1, 0);
    check("rst_shadow_gone_ch0", 32'(ms_high[0]), 32'd0);
    check("rst_shadow_gone_ch3", 32'(ms_high[3]), 32'd0);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
